// File: rtl/core_run_ctrl.sv
// Run controller beside rv32i_core: holds the core in reset after a start, runs it under a
// watchdog, and snoops data-memory writes to the tohost mailbox to decide pass or fail.
module core_run_ctrl #(
    parameter int          RST_HOLD_CYCLES = 2,
    parameter int unsigned RUN_CYCLES      = 50,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned CNT_W           = 32,
    parameter logic [63:0] TOHOST_ADDR     = 64'h0000_1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-2:0] test_code,
    output logic [CNT_W-1:0]  cycle_count
);

    if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
        $error("core_run_ctrl: RST_HOLD_CYCLES must be at least 1");
    end
    if ((TOHOST_ADDR >> ADDR_W) != 64'd0) begin : g_bad_tohost
        $error("core_run_ctrl: TOHOST_ADDR does not fit in ADDR_W bits");
    end

    localparam int unsigned       HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] TOHOST_A  = TOHOST_ADDR[ADDR_W-1:0];
    localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               core_rst_q, core_rst_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               timeout_q, timeout_d;
    logic [DATA_W-2:0]  test_code_q, test_code_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;

    logic mbox_hit;
    logic wd_expire;

    assign mbox_hit  = mem_wr_en && (mem_wr_addr == TOHOST_A);
    assign wd_expire = (RUN_CYCLES != 0) && (cycle_count_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            hold_q        <= '0;
            core_rst_q    <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            test_code_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            core_rst_q    <= core_rst_d;
            running_q     <= running_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            test_code_q   <= test_code_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        core_rst_d    = core_rst_q;
        running_d     = running_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        test_code_d   = test_code_q;
        cycle_count_d = cycle_count_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                core_rst_d = 1'b1;
                running_d  = 1'b0;
                if (start) begin
                    state_d       = S_RESET;
                    hold_d        = HOLD_LOAD;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    fail_d        = 1'b0;
                    timeout_d     = 1'b0;
                    test_code_d   = '0;
                    cycle_count_d = '0;
                end
            end
            S_RESET: begin
                core_rst_d = 1'b1;
                if (hold_q == '0) begin
                    state_d    = S_RUN;
                    core_rst_d = 1'b0;
                    running_d  = 1'b1;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_RUN: begin
                // The exit cycle is counted too, so the final count includes it.
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
                // A mailbox hit outranks a watchdog expiry in the same cycle.
                if (mbox_hit) begin
                    state_d    = S_DONE;
                    core_rst_d = 1'b1;
                    running_d  = 1'b0;
                    done_d     = 1'b1;
                    if (mem_wr_data == DATA_W'(1)) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d      = 1'b1;
                        test_code_d = mem_wr_data[DATA_W-1:1];
                    end
                end else if (wd_expire) begin
                    state_d    = S_DONE;
                    core_rst_d = 1'b1;
                    running_d  = 1'b0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_rst    = core_rst_q;
    assign running     = running_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign test_code   = test_code_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed and randomized runs predicted from a per-run write schedule.
module tb_core_run_ctrl;

    localparam int MAXK = 1100;
    localparam int RC   = 50;

    logic        clk = 1'b0;
    logic        rst_n, start, mem_wr_en;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic        core_rst, running, done, pass, fail, timeout;
    logic [30:0] test_code;
    logic [31:0] cycle_count;

    logic        b_start, b_mem_wr_en;
    logic [31:0] b_mem_wr_addr, b_mem_wr_data;
    logic        b_core_rst, b_running, b_done, b_pass, b_fail, b_timeout;
    logic [30:0] b_test_code;
    logic [31:0] b_cycle_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic        sch_en  [1:MAXK];
    logic [31:0] sch_a   [1:MAXK];
    logic [31:0] sch_d   [1:MAXK];
    logic        sch_st  [1:MAXK];

    always #5 clk = ~clk;

    core_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .core_rst(core_rst), .running(running), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .test_code(test_code), .cycle_count(cycle_count)
    );

    core_run_ctrl #(.RUN_CYCLES(0)) dut_nowd (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mem_wr_en(b_mem_wr_en),
        .mem_wr_addr(b_mem_wr_addr), .mem_wr_data(b_mem_wr_data),
        .core_rst(b_core_rst), .running(b_running), .done(b_done), .pass(b_pass),
        .fail(b_fail), .timeout(b_timeout), .test_code(b_test_code), .cycle_count(b_cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sched();
        for (int k = 1; k <= MAXK; k++) begin
            sch_en[k] = 1'b0;
            sch_a[k]  = 32'h0;
            sch_d[k]  = 32'h0;
            sch_st[k] = 1'b0;
        end
    endtask

    task automatic add_wr(input int k, input logic [31:0] a, input logic [31:0] d);
        sch_en[k] = 1'b1;
        sch_a[k]  = a;
        sch_d[k]  = d;
    endtask

    // Outcome of a run: the first RUN cycle carrying a tohost store ends it, unless the
    // watchdog limit is reached first; kind 0 = pass, 1 = fail, 2 = timeout.
    function automatic void predict(input int rc, output int kx, output int kind,
                                    output logic [30:0] code);
        logic [31:0] d;
        kx = 0; kind = 2; code = '0;
        for (int k = 1; k <= MAXK; k++) begin
            if (sch_en[k] && sch_a[k] == 32'h0000_1000) begin
                kx = k;
                d  = sch_d[k];
                if (d == 32'd1) kind = 0;
                else begin
                    kind = 1;
                    code = d[31:1];
                end
                return;
            end
            if (rc != 0 && k == rc) begin
                kx = k;
                kind = 2;
                return;
            end
        end
    endfunction

    task automatic run_check(input string tag, input bit poke_reset);
        int kx, kind, k;
        logic [30:0] code;
        predict(RC, kx, kind, code);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " rst_hold1"}, 32'(core_rst), 32'd1);
        chk({tag, " running_in_reset"}, 32'(running), 32'd0);
        chk({tag, " flags_cleared"}, 32'({done, pass, fail, timeout}), 32'd0);
        chk({tag, " count_cleared"}, cycle_count, 32'd0);
        chk({tag, " code_cleared"}, 32'(test_code), 32'd0);
        if (poke_reset) begin
            mem_wr_en = 1'b1; mem_wr_addr = 32'h1000; mem_wr_data = 32'd1;
        end
        @(negedge clk);
        mem_wr_en = 1'b0;
        chk({tag, " rst_hold2"}, 32'(core_rst), 32'd1);
        chk({tag, " reset_write_ignored"}, 32'({done, pass}), 32'd0);
        @(negedge clk);
        chk({tag, " rst_released"}, 32'(core_rst), 32'd0);
        chk({tag, " running"}, 32'(running), 32'd1);
        k = 1;
        while (running && k <= MAXK) begin
            chk({tag, " run_count"}, cycle_count, 32'(k - 1));
            mem_wr_en   = sch_en[k];
            mem_wr_addr = sch_a[k];
            mem_wr_data = sch_d[k];
            start       = sch_st[k];
            @(negedge clk);
            mem_wr_en = 1'b0;
            start     = 1'b0;
            k++;
        end
        chk({tag, " run_length"}, 32'(k - 1), 32'(kx));
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " pass"}, 32'(pass), 32'(kind == 0));
        chk({tag, " fail"}, 32'(fail), 32'(kind == 1));
        chk({tag, " timeout"}, 32'(timeout), 32'(kind == 2));
        chk({tag, " test_code"}, 32'(test_code), 32'(code));
        chk({tag, " final_count"}, cycle_count, 32'(kx));
        chk({tag, " core_halted"}, 32'({core_rst, running}), 32'b10);
        mem_wr_en = 1'b1; mem_wr_addr = 32'h1000;
        mem_wr_data = (kind == 0) ? 32'd6 : 32'd1;
        @(negedge clk);
        mem_wr_en = 1'b0;
        @(negedge clk);
        chk({tag, " done_hold"}, 32'({done, pass, fail, timeout}),
            32'({1'b1, kind == 0, kind == 1, kind == 2}));
        chk({tag, " count_hold"}, cycle_count, 32'(kx));
        chk({tag, " code_hold"}, 32'(test_code), 32'(code));
    endtask

    initial begin
        int bad;
        int sel;
        rst_n = 1'b0; start = 1'b0; mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
        b_start = 1'b0; b_mem_wr_en = 1'b0; b_mem_wr_addr = '0; b_mem_wr_data = '0;
        repeat (3) @(negedge clk);
        chk("reset core_rst", 32'(core_rst), 32'd1);
        chk("reset flags", 32'({running, done, pass, fail, timeout}), 32'd0);
        chk("reset test_code", 32'(test_code), 32'd0);
        chk("reset cycle_count", cycle_count, 32'd0);
        rst_n = 1'b1;
        mem_wr_en = 1'b1; mem_wr_addr = 32'h1000; mem_wr_data = 32'd1;
        @(negedge clk);
        mem_wr_en = 1'b0;
        @(negedge clk);
        chk("idle ignores write", 32'({core_rst, running, done, pass}), 32'b1000);

        clear_sched();
        run_check("timeout", 1'b1);

        clear_sched();
        add_wr(10, 32'h1000, 32'd1);
        run_check("pass10", 1'b0);

        clear_sched();
        add_wr(3, 32'h1004, 32'd1);
        add_wr(5, 32'h1000, 32'h0000_0007);
        run_check("fail7", 1'b0);

        clear_sched();
        add_wr(50, 32'h1000, 32'd1);
        run_check("collision", 1'b0);

        clear_sched();
        sch_st[2] = 1'b1; sch_st[7] = 1'b1; sch_st[15] = 1'b1;
        add_wr(30, 32'h1000, 32'd1);
        run_check("start_in_run", 1'b0);

        for (int r = 0; r < 6; r++) begin
            clear_sched();
            for (int k = 1; k <= 60; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    sel = int'($urandom_range(0, 29));
                    sch_en[k] = 1'b1;
                    sch_a[k]  = (sel == 0) ? 32'h1000 : (sel < 10) ? 32'h1004 : $urandom;
                    sch_d[k]  = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
                end
                sch_st[k] = ($urandom_range(0, 9) == 0);
            end
            run_check($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
        end

        clear_sched();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 1; k < 20; k++) @(negedge clk);
        chk("midrst running", 32'({running, cycle_count[7:0]}), 32'({1'b1, 8'd19}));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst core_rst", 32'(core_rst), 32'd1);
        chk("midrst running0", 32'(running), 32'd0);
        chk("midrst count0", cycle_count, 32'd0);
        chk("midrst flags", 32'({done, pass, fail, timeout}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst idle", 32'({core_rst, running}), 32'b10);
        clear_sched();
        add_wr(4, 32'h1000, 32'h0000_0100);
        run_check("after_midrst", 1'b0);

        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int k = 1; k <= 1000; k++) begin
            if (b_timeout || b_done || !b_running) bad++;
            @(negedge clk);
        end
        chk("nowd no_timeout", 32'(bad), 32'd0);
        chk("nowd count", b_cycle_count, 32'd1000);
        b_mem_wr_en = 1'b1; b_mem_wr_addr = 32'h1000; b_mem_wr_data = 32'd1;
        @(negedge clk);
        b_mem_wr_en = 1'b0;
        chk("nowd pass", 32'({b_done, b_pass, b_fail, b_timeout}), 32'b1100);
        chk("nowd final count", b_cycle_count, 32'd1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Synthesizable run controller for the rv32i_core. It generalises the fixed "hold reset, run N, finish" sequence into a parametrised reset sequencer, watchdog and pass/fail detector. It drives the core's active-high reset, counts run cycles, and snoops data-memory writes for a tohost mailbox store. It sits beside rv32i_core in both FPGA and simulation top levels, so benches and boards share one completion mechanism.

Parameters:
RST_HOLD_CYCLES, 2, cycles core_rst is held high after a start (min 1)
RUN_CYCLES, 50, watchdog limit in run cycles; 0 disables the watchdog
ADDR_W, 32, width of the snooped write address
DATA_W, 32, width of the snooped write data
CNT_W, 32, width of cycle_count
TOHOST_ADDR, 32'h0000_1000, mailbox address (ADDR_W bits)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
start  in  1  1-cycle pulse; begins a new run from IDLE or DONE
mem_wr_en  in  1  core data-memory write strobe
mem_wr_addr  in  ADDR_W  core data-memory write address
mem_wr_data  in  DATA_W  core data-memory write data
core_rst  out  1  active-high reset to rv32i_core
running  out  1  high while in RUN
done  out  1  sticky; run finished (pass, fail or timeout)
pass  out  1  sticky; tohost written with 1
fail  out  1  sticky; tohost written with a non-1 value
timeout  out  1  sticky; watchdog expired
test_code  out  DATA_W-1  mem_wr_data[DATA_W-1:1] captured on fail, else 0
cycle_count  out  CNT_W  RUN cycles elapsed in the current or last run

Behaviour:
- Clock is clk. Reset is rst_n: synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, core_rst=1, running=0, done=0, pass=0, fail=0, timeout=0, test_code=0, cycle_count=0, hold counter=0.
- FSM states: IDLE, RESET, RUN, DONE. All outputs are registered.
- IDLE:
  - core_rst=1.
  - start -> RESET. This clears done, pass, fail, timeout, test_code and cycle_count, and loads the hold counter with RST_HOLD_CYCLES-1.
- RESET:
  - core_rst=1; the hold counter decrements each cycle.
  - When the counter is 0 -> RUN on the next edge.
  - core_rst is high for exactly RST_HOLD_CYCLES cycles after the cycle that sampled start.
- RUN:
  - core_rst=0, running=1.
  - cycle_count increments by 1 each RUN cycle and saturates at all-ones (no wrap).
  - Mailbox hit: mem_wr_en=1 and mem_wr_addr==TOHOST_ADDR.
    - data==1 -> pass=1.
    - else -> fail=1, test_code=data>>1.
    - Either case: done=1 and -> DONE.
  - Writes to any other address are ignored.
  - Watchdog: if RUN_CYCLES!=0 and cycle_count==RUN_CYCLES-1 with no mailbox hit that cycle -> timeout=1, done=1, -> DONE.
  - A mailbox hit in the same cycle as watchdog expiry gives pass/fail, never timeout.
  - The write of the cycle is counted: cycle_count on exit includes the final RUN cycle.
- DONE:
  - core_rst=1 (core halted), running=0; all result outputs hold.
  - start -> RESET as from IDLE, giving a new run.
- start while in RESET or RUN is ignored.
- Mailbox writes outside RUN are ignored.
- Exactly one of pass/fail/timeout is set whenever done=1. All three are 0 while done=0.
- rst_n low in any state, including mid-RUN, returns to the reset values on that edge. core_rst stays high throughout.
- Elaboration error if RST_HOLD_CYCLES<1 or if TOHOST_ADDR does not fit in ADDR_W.

Test Plan:
- Reset then start, defaults: core_rst high for 2 cycles after the start edge, then low. With no tohost write, timeout=1 and done=1 when cycle_count=50. pass=fail=0.
- Pass: in RUN cycle 10, write addr=0x1000 data=1 -> pass=1, done=1, cycle_count=10, core_rst=1 next cycle, test_code=0.
- Fail: write addr=0x1000 data=0x0000_0007 -> fail=1, test_code=3, pass=0, timeout=0. A write to 0x1004 beforehand has no effect.
- Collision: RUN_CYCLES=50, tohost data=1 in the cycle where cycle_count==49 -> pass=1, timeout=0.
- Restart/ignore: start pulsed during RUN has no effect. start in DONE clears all flags, reruns the 2-cycle reset, and cycle_count restarts from 0.
- Mid-run reset: rst_n=0 at cycle 20 of RUN -> next edge core_rst=1, running=0, cycle_count=0, FSM in IDLE. With RUN_CYCLES=0, a 1000-cycle run never asserts timeout.
